// File: rtl/heading_pkg.sv
// Shared definitions for the heading producer: FSM state encoding, default
// calibration/scale parameters and the heading word width used by PD_math.
package heading_pkg;

   typedef enum logic [1:0] {IDLE, CAL, RUN} state_e;

   localparam int unsigned CAL_LOG2_DEF   = 11;
   localparam int unsigned HEAD_SHIFT_DEF = 11;
   localparam int unsigned HEAD_W         = 16;

endpackage

// File: rtl/heading_integrator_if.sv
// Sensor-to-PD_math heading bundle.
//   strt_cal, yaw_rt, rt_vld : driven by the sensor side (master)
//   heading, vld, cal_done   : driven by the integrator (slave)
interface heading_integrator_if;
   import heading_pkg::*;

   logic                     strt_cal;
   logic signed [HEAD_W-1:0] yaw_rt;
   logic                     rt_vld;
   logic signed [HEAD_W-1:0] heading;
   logic                     vld;
   logic                     cal_done;

   modport master (output strt_cal, yaw_rt, rt_vld, input heading, vld, cal_done);
   modport slave  (input strt_cal, yaw_rt, rt_vld, output heading, vld, cal_done);

endinterface

// File: rtl/heading_cal_avg.sv
// Gyro zero-rate offset averager.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear sum and sample counter (offset is kept)
//   sample   : accept yaw_rt into the running sum
//   yaw_rt   : signed raw rate sample
//   done     : this sample is the 2^CAL_LOG2-th one (combinational)
//   offset   : registered arithmetic-floor mean of the last calibration
module heading_cal_avg
   import heading_pkg::*;
#(
   parameter int unsigned CAL_LOG2 = CAL_LOG2_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     sample,
   input  logic signed [HEAD_W-1:0] yaw_rt,
   output logic                     done,
   output logic signed [HEAD_W-1:0] offset
);

   localparam int unsigned SW = HEAD_W + CAL_LOG2;

   logic signed [SW-1:0]     sum_q, sum_d, sum_nxt, avg;
   logic [CAL_LOG2-1:0]      cnt_q, cnt_d;
   logic signed [HEAD_W-1:0] offset_q, offset_d;

   always_comb begin
      sum_nxt  = sum_q + {{CAL_LOG2{yaw_rt[HEAD_W-1]}}, yaw_rt};
      avg      = sum_nxt >>> CAL_LOG2;
      done     = sample && (cnt_q == '1);
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      offset_d = offset_q;
      if (clr) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (sample) begin
         if (done) begin
            // final sample is folded in combinationally so the offset is ready on this edge
            offset_d = avg[HEAD_W-1:0];
            sum_d    = '0;
            cnt_d    = '0;
         end else begin
            sum_d = sum_nxt;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q    <= '0;
         cnt_q    <= '0;
         offset_q <= '0;
      end else begin
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         offset_q <= offset_d;
      end
   end

   assign offset = offset_q;

endmodule

// File: rtl/heading_integrator.sv
// Converts gyro yaw-rate samples into the signed heading and one-cycle valid
// strobe consumed by PD_math. Calibrates the zero-rate offset first, then
// integrates offset-corrected rate; heading wraps as an angle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of heading_integrator_if
//              (strt_cal, yaw_rt, rt_vld in; heading, vld, cal_done out)
module heading_integrator
   import heading_pkg::*;
#(
   parameter int unsigned CAL_LOG2   = CAL_LOG2_DEF,
   parameter int unsigned HEAD_SHIFT = HEAD_SHIFT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   heading_integrator_if.slave  bus
);

   localparam int unsigned AW = 17 + HEAD_SHIFT;

   state_e                   state_q, state_d;
   logic [AW-1:0]            acc_q, acc_d, acc_sum;
   logic signed [HEAD_W-1:0] heading_q, heading_d;
   logic                     vld_q, vld_d;
   logic                     cal_done_q, cal_done_d;

   logic                     cal_clr, cal_sample, cal_last;
   logic signed [HEAD_W-1:0] offset;
   logic signed [16:0]       diff;

   // strt_cal is ignored while calibrating, so the averager is only cleared outside CAL
   assign cal_clr    = bus.strt_cal && (state_q != CAL);
   assign cal_sample = bus.rt_vld && (state_q == CAL);

   heading_cal_avg #(.CAL_LOG2(CAL_LOG2)) u_cal (
      .clk    (clk),
      .rst    (rst),
      .clr    (cal_clr),
      .sample (cal_sample),
      .yaw_rt (bus.yaw_rt),
      .done   (cal_last),
      .offset (offset)
   );

   always_comb begin
      diff       = {bus.yaw_rt[HEAD_W-1], bus.yaw_rt} - {offset[HEAD_W-1], offset};
      acc_sum    = acc_q + {{HEAD_SHIFT{diff[16]}}, diff};
      state_d    = state_q;
      acc_d      = acc_q;
      heading_d  = heading_q;
      vld_d      = 1'b0;
      cal_done_d = cal_done_q;
      case (state_q)
         IDLE: begin
            if (bus.strt_cal) state_d = CAL;
         end
         CAL: begin
            if (cal_last) begin
               state_d    = RUN;
               cal_done_d = 1'b1;
               acc_d      = '0;
            end
         end
         RUN: begin
            if (bus.strt_cal) begin
               state_d    = CAL;
               cal_done_d = 1'b0;
               acc_d      = '0;
               heading_d  = '0;
            end else if (bus.rt_vld) begin
               acc_d     = acc_sum;
               heading_d = acc_sum[HEAD_SHIFT+HEAD_W-1:HEAD_SHIFT];
               vld_d     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         heading_q  <= '0;
         vld_q      <= 1'b0;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         heading_q  <= heading_d;
         vld_q      <= vld_d;
         cal_done_q <= cal_done_d;
      end
   end

   assign bus.heading  = heading_q;
   assign bus.vld      = vld_q;
   assign bus.cal_done = cal_done_q;

endmodule
